// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path.
//  - core_sig request encodings from the pipeline core
//  - transmit FSM state type
//  - 8N1 frame constants and a byte-select helper for word requests
package uart_tx_fifo_pkg;

  // core_sig encodings: bit 1 = request valid, bit 0 = word (1) / byte (0)
  localparam logic [1:0] SIG_NONE = 2'b00;
  localparam logic [1:0] SIG_BYTE = 2'b10;
  localparam logic [1:0] SIG_WORD = 2'b11;

  // 8N1 framing
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // The LOAD step is folded into the pop cycle, so it has no state of its own
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // Byte idx of a little-endian word: idx 0 -> [7:0], idx 3 -> [31:24]
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    return 8'(word >> {idx, 3'b000});
  endfunction

endpackage

// File: rtl/uart_tx_fifo_req_fifo.sv
// tx_req_fifo: synchronous request FIFO, single clock.
//  Ports:
//   clk        in   clock, posedge
//   rst        in   synchronous active-high reset (empties the FIFO)
//   push       in   write request; ignored while full, even if a pop happens the same cycle
//   push_data  in   WIDTH-bit entry
//   pop        in   read request; ignored while empty
//   pop_data   out  head entry (valid while not empty)
//   full       out  count == 2**DEPTH_LOG2
//   empty      out  count == 0
//   count      out  number of stored entries
module tx_req_fifo #(
  parameter int WIDTH      = 33,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Full is decided from the registered count only, so a pop cannot make room
  // for a push in the same cycle.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH because they are DEPTH_LOG2 bits wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit end of the host UART link.
//  Buffers byte/word requests from the core and serialises them as 8N1 frames,
//  word requests as four back-to-back frames, least significant byte first.
//  Ports:
//   clk           in   core clock, posedge
//   rst           in   synchronous active-high reset
//   send_data     in   32-bit payload, byte requests use [7:0]
//   core_sig      in   00/01 none, 10 send byte, 11 send word
//   output_stall  out  FIFO full, request not taken this cycle
//   txd           out  serial line, idle high
//   tx_busy       out  FIFO non-empty or frame in progress
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 521,
  parameter int DEPTH_LOG2       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] send_data,
  input  logic [1:0]  core_sig,
  output logic        output_stall,
  output logic        txd,
  output logic        tx_busy
);

  localparam int BIT_PERIOD = 2 * CLK_PER_HALF_BIT;
  localparam int TIMER_W    = $clog2(BIT_PERIOD);
  localparam int BIT_IDX_W  = $clog2(DATA_BITS);
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(BIT_PERIOD - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT   = BIT_IDX_W'(DATA_BITS - 1);

  tx_state_t             state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic [31:0]           word_q, word_d;
  logic                  size_q, size_d;
  logic                  timer_done;

  logic                  fifo_pop;
  logic [32:0]           fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DEPTH_LOG2:0]   fifo_count;

  // Each entry is {is_word, payload}; core_sig[1] is the request strobe.
  tx_req_fifo #(
    .WIDTH      (33),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (core_sig[1]),
    .push_data ({core_sig == SIG_WORD, send_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign output_stall = fifo_full;
  assign tx_busy      = (state_q != ST_IDLE) || (fifo_count != '0);
  assign timer_done   = (timer_q == TIMER_LAST);

  // State, bit timer and shift path registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      size_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      size_q     <= size_d;
    end
  end

  // Next-state and line driver. Every state entry clears the bit timer, so each
  // state lasts exactly one bit period (DATA lasts eight). Popping the FIFO loads
  // the head directly and enters START, which keeps word bytes and queued
  // requests back-to-back with no idle gap.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + TIMER_W'(1);
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    word_d     = word_q;
    size_d     = size_q;
    fifo_pop   = 1'b0;
    txd        = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        txd     = 1'b1;
        timer_d = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          word_d     = fifo_head[31:0];
          size_d     = fifo_head[32];
          shift_d    = fifo_head[7:0];
          byte_idx_d = '0;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        txd = 1'b0;
        if (timer_done) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        txd = shift_q[0];
        if (timer_done) begin
          timer_d = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end

      ST_STOP: begin
        txd = 1'b1;
        if (timer_done) begin
          timer_d = '0;
          if (size_q && (byte_idx_q != 2'd3)) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = word_byte(word_q, byte_idx_q + 2'd1);
            state_d    = ST_START;
          end else if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            word_d     = fifo_head[31:0];
            size_d     = fifo_head[32];
            shift_d    = fifo_head[7:0];
            byte_idx_d = '0;
            state_d    = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo with a fast bit clock (8 cycles per bit) and a
// 4-entry FIFO. A UART monitor decodes txd mid-bit into rx_q; a byte-level
// reference queue exp_q is filled from each accepted request.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  localparam int HALF_BIT = 4;
  localparam int DEPTH_L2 = 2;
  localparam int BIT_CYC  = 2 * HALF_BIT;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] send_data;
  logic [1:0]  core_sig;
  logic        output_stall;
  logic        txd;
  logic        tx_busy;

  int          n_checks = 0;
  int          n_errors = 0;
  int          stall_cycles;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  mon_byte;
  bit          mon_abort;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_PER_HALF_BIT (HALF_BIT),
    .DEPTH_LOG2       (DEPTH_L2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .send_data    (send_data),
    .core_sig     (core_sig),
    .output_stall (output_stall),
    .txd          (txd),
    .tx_busy      (tx_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one request at a negedge, holds it while stalled, and returns at the
  // negedge after the accepting posedge. The reference queue gets its bytes then.
  task automatic applyStimulus(input logic [1:0] sig, input logic [31:0] data);
    int guard;
    core_sig  = sig;
    send_data = data;
    guard     = 0;
    while (output_stall === 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    stall_cycles = guard;
    if (guard >= 2000) checkOutput("stall_timeout", 32'd1, 32'd0);
    @(negedge clk);
    if (sig == SIG_BYTE) begin
      exp_q.push_back(data[7:0]);
    end else begin
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((data >> (8 * i)) & 32'hFF));
    end
    core_sig  = SIG_NONE;
    send_data = $urandom;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) checkOutput("drain_timeout", 32'd1, 32'd0);
    repeat (2 * BIT_CYC) @(negedge clk);
  endtask

  task automatic compareQueues(input string tag);
    checkOutput({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      checkOutput($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  // UART monitor: a low sample starts a frame; samples then fall near mid-bit.
  // A reset during the frame discards it.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && txd === 1'b0) begin
        mon_abort = 1'b0;
        repeat (HALF_BIT - 1) begin
          @(negedge clk);
          if (rst) mon_abort = 1'b1;
        end
        if (!mon_abort) checkOutput("start_bit", txd, 32'd0);
        for (int i = 0; i < DATA_BITS; i++) begin
          repeat (BIT_CYC) begin
            @(negedge clk);
            if (rst) mon_abort = 1'b1;
          end
          mon_byte[i] = txd;
        end
        repeat (BIT_CYC) begin
          @(negedge clk);
          if (rst) mon_abort = 1'b1;
        end
        if (!mon_abort) begin
          checkOutput("stop_bit", txd, 32'd1);
          rx_q.push_back(mon_byte);
        end
      end
    end
  end

  initial begin
    int cyc;
    int bad;

    // Reset state
    rst       = 1'b1;
    core_sig  = SIG_NONE;
    send_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_txd", txd, 32'd1);
    checkOutput("reset_stall", output_stall, 32'd0);
    checkOutput("reset_busy", tx_busy, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0xAA: latency, frame length, content
    core_sig  = SIG_BYTE;
    send_data = 32'h0000_00AA;
    @(negedge clk);
    exp_q.push_back(8'hAA);
    core_sig = SIG_NONE;
    checkOutput("byte_txd_before_start", txd, 32'd1);
    checkOutput("byte_busy", tx_busy, 32'd1);
    @(negedge clk);
    checkOutput("byte_start_latency", txd, 32'd0);
    cyc = 0;
    while (tx_busy === 1'b1 && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    checkOutput("byte_frame_cycles", cyc, 32'd80);
    waitDrain(500);
    compareQueues("byte");

    // Single word 0x12345678: four frames back-to-back = 320 cycles
    core_sig  = SIG_WORD;
    send_data = 32'h1234_5678;
    @(negedge clk);
    exp_q.push_back(8'h78);
    exp_q.push_back(8'h56);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    core_sig = SIG_NONE;
    @(negedge clk);
    checkOutput("word_start_latency", txd, 32'd0);
    cyc = 0;
    while (tx_busy === 1'b1 && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    checkOutput("word_frame_cycles", cyc, 32'd320);
    waitDrain(500);
    compareQueues("word");

    // Full FIFO: a byte occupies the FSM, four words fill the FIFO, the fifth is
    // held until the byte frame ends (popped one cycle after push, 80 cycles long).
    applyStimulus(SIG_BYTE, $urandom);
    for (int w = 0; w < 4; w++) applyStimulus(SIG_WORD, $urandom);
    checkOutput("full_stall", output_stall, 32'd1);
    checkOutput("full_busy", tx_busy, 32'd1);
    applyStimulus(SIG_WORD, $urandom);
    checkOutput("full_stall_cycles", stall_cycles, 32'd77);
    waitDrain(4000);
    compareQueues("full");

    // Pointer wrap: 12 bytes through a 4-deep FIFO
    for (int i = 0; i < 12; i++) applyStimulus(SIG_BYTE, 32'(i));
    waitDrain(3000);
    compareQueues("wrap");

    // Random mix of bytes and words with random gaps
    for (int i = 0; i < 20; i++) begin
      applyStimulus(($urandom_range(0, 1) == 1) ? SIG_WORD : SIG_BYTE, $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    waitDrain(10000);
    compareQueues("random");

    // Reset mid-frame during data bit 3 of 0x55 with a second byte queued
    applyStimulus(SIG_BYTE, 32'h55);
    applyStimulus(SIG_BYTE, 32'h99);
    repeat (34) @(negedge clk);
    checkOutput("pre_reset_bit3", txd, 32'd0);
    checkOutput("pre_reset_busy", tx_busy, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_txd", txd, 32'd1);
    checkOutput("midreset_stall", output_stall, 32'd0);
    checkOutput("midreset_busy", tx_busy, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (120) @(negedge clk);
    checkOutput("midreset_no_output", rx_q.size(), 32'd0);
    applyStimulus(SIG_BYTE, 32'hC3);
    waitDrain(500);
    compareQueues("after_reset");

    // Idle: core_sig 00/01 never pushes
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      core_sig  = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
      send_data = $urandom;
      @(negedge clk);
      if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    core_sig = SIG_NONE;
    checkOutput("idle_bad_samples", bad, 32'd0);
    checkOutput("idle_stall", output_stall, 32'd0);
    repeat (2 * BIT_CYC) @(negedge clk);
    checkOutput("idle_no_frames", rx_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
